multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 134 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle processor main controller: Moore FSM producing datapath selects,
// condition-gated write enables and a retired-instruction counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic [3:0]  Rd,
    input  logic        CondEx,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUOp,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  State,
    output logic [31:0] InstrCount
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instrCount_q, instrCount_d;
    logic        nextPC, regW, memW, branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            instrCount_q <= '0;
        end else begin
            state_q      <= state_d;
            instrCount_q <= instrCount_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    // An instruction retires on the edge that returns the FSM to FETCH.
    always_comb begin
        instrCount_d = instrCount_q;
        if (state_d == FETCH && state_q != FETCH) begin
            instrCount_d = instrCount_q + 32'd1;
        end
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUOp     = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        nextPC    = 1'b0;
        regW      = 1'b0;
        memW      = 1'b0;
        branch    = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                nextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                memW   = 1'b1;
            end
            EXECR:  ALUOp = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            // Compare/test commands only set flags, so no register write-back.
            ALUWB:  regW = (Funct[4:3] != 2'b10);
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign RegWrite   = regW & CondEx;
    assign MemWrite   = memW & CondEx;
    assign PCWrite    = nextPC | (branch & CondEx) | (regW & CondEx & (Rd == 4'd15));
    assign State      = state_q;
    assign InstrCount = instrCount_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model,
// per-cycle compare process, directed literal traces and randomized instructions.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd;
    logic        CondEx;
    logic        IRWrite, AdrSrc, ALUOp, PCWrite, RegWrite, MemWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0]  State;
    logic [31:0] InstrCount;

    int checks = 0;
    int errors = 0;

    logic        checkEn = 1'b0;
    int          expState = 0;
    logic [31:0] expCount = 0;

    logic [31:0] stTrace;
    logic [7:0]  rwTrace, mwTrace, pcTrace;
    int          traceLen;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .State(State), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    typedef struct packed {
        logic       ir, adr, aluop;
        logic [1:0] sa, sb, rs;
        logic       pcw, rw, mw;
    } ctl_t;

    // Outputs required in a given state for the instruction currently held on the inputs.
    function automatic ctl_t expected(input int st);
        ctl_t c;
        logic rawRegW, rawMemW, rawBr, rawPC;
        c = '0;
        rawRegW = 0; rawMemW = 0; rawBr = 0; rawPC = 0;
        case (st)
            0: begin c.ir = 1; rawPC = 1; c.sa = 2'b01; c.sb = 2'b10; c.rs = 2'b10; end
            1: begin c.sa = 2'b01; c.sb = 2'b10; c.rs = 2'b10; end
            2: c.sb = 2'b01;
            3: c.adr = 1;
            4: begin c.rs = 2'b01; rawRegW = 1; end
            5: begin c.adr = 1; rawMemW = 1; end
            6: c.aluop = 1;
            7: begin c.sb = 2'b01; c.aluop = 1; end
            8: rawRegW = (Funct[4:3] != 2'b10);
            9: begin c.sb = 2'b01; c.rs = 2'b10; rawBr = 1; end
            default: ;
        endcase
        c.rw  = rawRegW && CondEx;
        c.mw  = rawMemW && CondEx;
        c.pcw = rawPC || (rawBr && CondEx) || (c.rw && Rd == 4'd15);
        return c;
    endfunction

    // Compare process: every falling edge while the model is tracking the DUT.
    always @(negedge clk) begin
        if (checkEn) begin
            ctl_t e;
            e = expected(expState);
            checkOutput("State", 32'(State), 32'(expState));
            checkOutput("InstrCount", InstrCount, expCount);
            checkOutput("IRWrite", 32'(IRWrite), 32'(e.ir));
            checkOutput("AdrSrc", 32'(AdrSrc), 32'(e.adr));
            checkOutput("ALUOp", 32'(ALUOp), 32'(e.aluop));
            checkOutput("ALUSrcA", 32'(ALUSrcA), 32'(e.sa));
            checkOutput("ALUSrcB", 32'(ALUSrcB), 32'(e.sb));
            checkOutput("ResultSrc", 32'(ResultSrc), 32'(e.rs));
            checkOutput("PCWrite", 32'(PCWrite), 32'(e.pcw));
            checkOutput("RegWrite", 32'(RegWrite), 32'(e.rw));
            checkOutput("MemWrite", 32'(MemWrite), 32'(e.mw));
            stTrace  = (stTrace << 4) | 32'(State);
            rwTrace  = (rwTrace << 1) | 8'(RegWrite);
            mwTrace  = (mwTrace << 1) | 8'(MemWrite);
            pcTrace  = (pcTrace << 1) | 8'(PCWrite);
            traceLen = traceLen + 1;
        end
    end

    task automatic clearTrace();
        stTrace = 0; rwTrace = 0; mwTrace = 0; pcTrace = 0; traceLen = 0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_State"}, 32'(State), 0);
        checkOutput({tag, "_Count"}, InstrCount, 0);
        checkOutput({tag, "_IRWrite"}, 32'(IRWrite), 1);
        checkOutput({tag, "_PCWrite"}, 32'(PCWrite), 1);
        checkOutput({tag, "_RegWrite"}, 32'(RegWrite), 0);
        checkOutput({tag, "_MemWrite"}, 32'(MemWrite), 0);
    endtask

    // Runs one instruction from FETCH; abortIdx >= 0 pulses reset once that state is reached.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                                 input logic [3:0] rd, input logic cond, input int abortIdx);
        int seq[$];
        seq = '{0, 1};
        case (op)
            2'b00: begin seq.push_back(funct[5] ? 7 : 6); seq.push_back(8); end
            2'b01: begin
                seq.push_back(2);
                if (funct[0]) begin seq.push_back(3); seq.push_back(4); end
                else seq.push_back(5);
            end
            2'b10: seq.push_back(9);
            default: ;
        endcase
        Op = op; Funct = funct; Rd = rd; CondEx = cond;
        expState = 0;
        for (int k = 1; k < seq.size(); k++) begin
            @(posedge clk); #1;
            expState = seq[k];
            if (k == abortIdx) begin
                @(negedge clk); #2;
                checkEn = 1'b0;
                reset = 1'b1;
                #1;
                checkReset("abort");
                @(posedge clk); #1;
                checkOutput("abort_hold_State", 32'(State), 0);
                reset = 1'b0;
                expState = 0;
                expCount = 0;
                checkEn = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
        expState = 0;
        expCount = expCount + 32'd1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; Op = 0; Funct = 0; Rd = 0; CondEx = 0;
        clearTrace();
        #1;
        checkReset("rst_async");
        repeat (3) @(posedge clk);
        #1;
        checkReset("rst_clocked");
        reset = 1'b0;
        checkEn = 1'b1;

        // LDR
        clearTrace();
        applyStimulus(2'b01, 6'b011001, 4'd3, 1'b1, -1);
        checkOutput("ldr_states", stTrace, 32'h01234);
        checkOutput("ldr_regwrite", 32'(rwTrace), 32'b00001);
        checkOutput("ldr_len", traceLen, 5);
        checkOutput("ldr_count", InstrCount, 1);

        // STR with failing condition
        clearTrace();
        applyStimulus(2'b01, 6'b011000, 4'd3, 1'b0, -1);
        checkOutput("str_states", stTrace, 32'h0125);
        checkOutput("str_memwrite", 32'(mwTrace), 0);
        checkOutput("str_len", traceLen, 4);
        checkOutput("str_count", InstrCount, 2);

        // CMP
        clearTrace();
        applyStimulus(2'b00, 6'b010101, 4'd2, 1'b1, -1);
        checkOutput("cmp_states", stTrace, 32'h0168);
        checkOutput("cmp_regwrite", 32'(rwTrace), 0);

        // ADD immediate into PC
        clearTrace();
        applyStimulus(2'b00, 6'b101000, 4'd15, 1'b1, -1);
        checkOutput("addpc_states", stTrace, 32'h0178);
        checkOutput("addpc_regwrite", 32'(rwTrace), 32'b0001);
        checkOutput("addpc_pcwrite", 32'(pcTrace), 32'b1001);

        // Branch taken then not taken
        clearTrace();
        applyStimulus(2'b10, 6'b000000, 4'd0, 1'b1, -1);
        checkOutput("b_taken_states", stTrace, 32'h019);
        checkOutput("b_taken_pcwrite", 32'(pcTrace), 32'b101);
        clearTrace();
        applyStimulus(2'b10, 6'b000000, 4'd0, 1'b0, -1);
        checkOutput("b_nottaken_pcwrite", 32'(pcTrace), 32'b100);
        checkOutput("b_len", traceLen, 3);

        // Undefined opcode
        clearTrace();
        applyStimulus(2'b11, 6'b111111, 4'd15, 1'b1, -1);
        checkOutput("undef_states", stTrace, 32'h01);
        checkOutput("undef_writes", 32'(rwTrace | mwTrace), 0);
        checkOutput("undef_count", InstrCount, 7);

        // Reset while in MEMRD
        applyStimulus(2'b01, 6'b000001, 4'd1, 1'b1, 3);

        // Counter wrap from a preloaded all-ones value
        force dut.instrCount_q = 32'hFFFF_FFFF;
        #1;
        release dut.instrCount_q;
        expCount = 32'hFFFF_FFFF;
        applyStimulus(2'b10, 6'b000000, 4'd0, 1'b1, -1);
        checkOutput("wrap_count", InstrCount, 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 6'($urandom),
                          ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                          1'($urandom), -1);
        end

        @(negedge clk);
        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
